// File: rtl/aes_pkg.sv
// AES tables, types and GF(2^8) helpers shared by the cipher and inverse cores.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYEXP,
    S_ROUND,
    S_DONE
  } fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [0:7][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {SBOX[w[31:24]], SBOX[w[23:16]],
            SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] inv_mix_column(
    input logic [31:0] c
  );
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[31-8*i -: 8];
      x2[i]  = xtime(a[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m9[i]  = x8[i] ^ a[i];
      m11[i] = x8[i] ^ x2[i] ^ a[i];
      m13[i] = x8[i] ^ x4[i] ^ a[i];
      m14[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0] ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1] ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2] ^ m14[3]};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_i.
module aes_inv_round
  import aes_pkg::*;
(
  input  state_t state_i,
  input  state_t rkey_i,
  input  logic   last_i,
  output state_t state_o
);

  state_t sb;
  state_t ark;
  state_t mix;

  always_comb begin
    sb  = '0;
    mix = '0;
    // row r rotates right by r: out[r][c] = in[r][c-r]
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sb[127-8*(4*c+r) -: 8] =
          INV_SBOX[state_i[127-8*(4*((c-r+4)%4)+r) -: 8]];
      end
    end
    ark = sb ^ rkey_i;
    for (int c = 0; c < 4; c++) begin
      mix[127-32*c -: 32] =
        inv_mix_column(ark[127-32*c -: 32]);
    end
  end

  assign state_o = last_i ? ark : mix;

endmodule

// File: rtl/aes_inv_top.sv
// Iterative AES-256 inverse cipher, one round per clock.
// Optional last-key cache: define AES_INV_KEY_CACHE_EN.
module aes_inv_top
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [255:0] key_i,
  input  state_t       ciphertext_i,
  output state_t       plaintext_o,
  output logic         done_o,
  output logic         busy_o
);

  fsm_e        fsm;
  state_t      st;
  state_t      rk [15];
  logic [3:0]  k;
  logic [3:0]  r;
  logic        hit;
  logic        accept;
  logic        kexp_last;
  state_t      prev;
  state_t      prev2;
  state_t      rk_new;
  state_t      rnd_out;
  logic [31:0] temp;
  logic [31:0] w0;
  logic [31:0] w1;
  logic [31:0] w2;
  logic [31:0] w3;

  assign accept    = (fsm == S_IDLE) && start_i;
  assign kexp_last = (k == 4'd14);

  always_comb begin
    prev  = rk[k - 4'd1];
    prev2 = rk[k - 4'd2];
    if (!k[0]) begin
      temp = sub_word(rot_word(prev[31:0]))
           ^ {RCON[k[3:1]], 24'h0};
    end else begin
      temp = sub_word(prev[31:0]);
    end
    w0     = prev2[127:96] ^ temp;
    w1     = prev2[95:64] ^ w0;
    w2     = prev2[63:32] ^ w1;
    w3     = prev2[31:0] ^ w2;
    rk_new = {w0, w1, w2, w3};
  end

`ifdef AES_INV_KEY_CACHE_EN
  logic [255:0] key_q;
  logic         key_vld;

  // valid drops as soon as the buffer starts being overwritten
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_vld <= 1'b0;
      key_q   <= '0;
    end else if (accept && !hit) begin
      key_vld <= 1'b0;
      key_q   <= key_i;
    end else if (fsm == S_KEYEXP && kexp_last) begin
      key_vld <= 1'b1;
    end
  end

  assign hit = key_vld && (key_i == key_q);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (accept && !hit) begin
        rk[0] <= key_i[255:128];
        rk[1] <= key_i[127:0];
      end
      if (fsm == S_KEYEXP) begin
        rk[k] <= rk_new;
      end
    end
  end

  aes_inv_round u_round (
    .state_i (st),
    .rkey_i  (rk[r]),
    .last_i  (r == 4'd0),
    .state_o (rnd_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm         <= S_IDLE;
      st          <= '0;
      k           <= '0;
      r           <= '0;
      plaintext_o <= '0;
      done_o      <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (fsm)
        S_IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            k      <= 4'd2;
            r      <= 4'd13;
            if (hit) begin
              st  <= ciphertext_i ^ rk[14];
              fsm <= S_ROUND;
            end else begin
              st  <= ciphertext_i;
              fsm <= S_KEYEXP;
            end
          end
        end
        S_KEYEXP: begin
          if (kexp_last) begin
            st  <= st ^ rk_new;
            fsm <= S_ROUND;
          end else begin
            k <= k + 4'd1;
          end
        end
        S_ROUND: begin
          st <= rnd_out;
          if (r == 4'd0) begin
            plaintext_o <= rnd_out;
            done_o      <= 1'b1;
            fsm         <= S_DONE;
          end else begin
            r <= r - 4'd1;
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          fsm    <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_top.sv
// Scoreboard bench for aes_inv_top: known vectors, abort, cache
// and random blocks encrypted by a forward-cipher model.
module tb_aes_inv_top;
  import aes_pkg::*;

`ifdef AES_INV_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [255:0] C3_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam state_t C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam state_t C3_PT = 128'h00112233445566778899aabbccddeeff;
  localparam state_t Z_CT  = 128'hdc95c078a2408989ad48a21492842087;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [255:0] key_i = '0;
  state_t       ciphertext_i = '0;
  state_t       plaintext_o;
  logic         done_o;
  logic         busy_o;

  typedef struct {
    state_t pt;
    int     lat;
  } exp_t;

  exp_t         exp_q [$];
  exp_t         e_mon;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           t_start = 0;
  int           gap = 0;
  int           t1 = 0;
  bit           prev_done = 1'b0;
  bit           m_vld = 1'b0;
  logic [255:0] m_key = '0;
  logic [255:0] k2;
  state_t       ct2;
  logic [255:0] rkey;
  state_t       rpt;

  aes_inv_top dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .key_i        (key_i),
    .ciphertext_i (ciphertext_i),
    .plaintext_o  (plaintext_o),
    .done_o       (done_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m2(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
  endfunction

  function automatic state_t aes_enc(input logic [255:0] key,
                                     input state_t pt);
    logic [31:0] w [60];
    logic [31:0] t;
    state_t      s;
    state_t      u;
    logic [7:0]  a0, a1, a2, a3;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)
        t = sub_word(rot_word(t)) ^ {RCON[i/8], 24'h0};
      else if (i % 8 == 4)
        t = sub_word(t);
      w[i] = w[i-8] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int rd = 1; rd <= 14; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          u[127-8*(4*c+r) -: 8] =
            SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
      if (rd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = u[127-32*c -: 8];
          a1 = u[119-32*c -: 8];
          a2 = u[111-32*c -: 8];
          a3 = u[103-32*c -: 8];
          u[127-32*c -: 8] = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
          u[119-32*c -: 8] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
          u[111-32*c -: 8] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
          u[103-32*c -: 8] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
      end
      s = u ^ {w[4*rd], w[4*rd+1], w[4*rd+2], w[4*rd+3]};
    end
    return s;
  endfunction

  always @(posedge clk_i) begin
    #1;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 128'(done_o), 128'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("plaintext", plaintext_o, e_mon.pt);
        check("latency", 128'(cyc - t_start + 1), 128'(e_mon.lat));
        check("busy_gap", 128'(gap), 128'd0);
        check("done_pulse", 128'(prev_done), 128'd0);
      end
    end else if (exp_q.size() != 0 && !busy_o) begin
      gap++;
    end
    prev_done = done_o;
  end

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) begin @(posedge clk_i); #1; end
    exp_q.delete();
    m_vld = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic request(input logic [255:0] key,
                         input state_t ct,
                         input state_t pt);
    int n;
    bit hit;
    n = 0;
    while (busy_o !== 1'b0 && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    if (n == 200) check("idle_timeout", 128'(busy_o), 128'd0);
    hit = CACHE && m_vld && (key == m_key);
    key_i        = key;
    ciphertext_i = ct;
    start_i      = 1'b1;
    exp_q.push_back('{pt, hit ? 15 : 28});
    m_vld = 1'b1;
    m_key = key;
    @(posedge clk_i); #1;
    t_start      = cyc;
    gap          = 0;
    start_i      = 1'b0;
    key_i        = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
    ciphertext_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic pulse_garbage();
    start_i      = 1'b1;
    key_i        = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
    ciphertext_i = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    do_reset();
    check("rst_plaintext", plaintext_o, 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);

    request(C3_KEY, C3_CT, C3_PT);
    check("busy_after_start", 128'(busy_o), 128'd1);
    t1 = t_start;
    request(256'd0, Z_CT, 128'd0);
    check("held_result", plaintext_o, C3_PT);
    check("b2b_period", 128'(t_start - t1), 128'd29);
    wait_done();

    request(C3_KEY, C3_CT, C3_PT);
    repeat (4) begin @(posedge clk_i); #1; end
    pulse_garbage();
    repeat (12) begin @(posedge clk_i); #1; end
    pulse_garbage();
    wait_done();

    request(256'd0, Z_CT, 128'd0);
    repeat (19) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("abort_busy", 128'(busy_o), 128'd0);
    check("abort_plaintext", plaintext_o, 128'd0);
    check("abort_done", 128'(done_o), 128'd0);
    exp_q.delete();
    m_vld = 1'b0;
    rst_i = 1'b0;
    repeat (40) begin @(posedge clk_i); #1; end
    request(C3_KEY, C3_CT, C3_PT);
    wait_done();

    request(C3_KEY, C3_CT, C3_PT);
    wait_done();
    k2  = C3_KEY ^ 256'd1;
    ct2 = aes_enc(k2, C3_PT);
    request(k2, ct2, C3_PT);
    wait_done();
    do_reset();
    request(k2, ct2, C3_PT);
    wait_done();

    for (int i = 0; i < 1000; i++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      request(rkey, aes_enc(rkey, rpt), rpt);
    end
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
